// File: rtl/jalr_wait_queue.sv
`default_nettype none
// ============================================================================
// Module   : jalr_wait_queue
// Purpose  : Fetch-side holding buffer for JALR instructions whose base
//            register is not yet readable. Up to four pending JALRs are held
//            in a circular buffer. Slot i is presented to forwarding port i.
//            The oldest entry retires, in program order, once its port reports
//            ready. Retiring produces a registered PC redirect back to fetch.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   discard all entries (highest priority)
//   alloc_v0/alloc_v1       lane 0 (older) / lane 1 (younger) JALR valid
//   alloc_{rs1,imm,pc,rd}_* per-lane JALR fields
//   alloc_ready             at least two free slots (pre-retire count)
//   slot_rs1_0..3           rs1 of each slot, 0 when the slot is empty
//   slot_ready_0..3         forwarding unit: rs1 of slot i readable now
//   slot_data_0..3          forwarded rs1 value for slot i
//   redir_valid             one-cycle redirect pulse
//   redir_target/link/rd    redirect payload, held between pulses
//   count                   occupied slots, 0..4
//   stall_cycles            saturating count of head-valid-but-not-ready
// ============================================================================
module jalr_wait_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        alloc_v0,
    input  logic        alloc_v1,
    input  logic [4:0]  alloc_rs1_0,
    input  logic [4:0]  alloc_rs1_1,
    input  logic [11:0] alloc_imm_0,
    input  logic [11:0] alloc_imm_1,
    input  logic [31:0] alloc_pc_0,
    input  logic [31:0] alloc_pc_1,
    input  logic [4:0]  alloc_rd_0,
    input  logic [4:0]  alloc_rd_1,
    output logic        alloc_ready,
    output logic [4:0]  slot_rs1_0,
    output logic [4:0]  slot_rs1_1,
    output logic [4:0]  slot_rs1_2,
    output logic [4:0]  slot_rs1_3,
    input  logic        slot_ready_0,
    input  logic        slot_ready_1,
    input  logic        slot_ready_2,
    input  logic        slot_ready_3,
    input  logic [31:0] slot_data_0,
    input  logic [31:0] slot_data_1,
    input  logic [31:0] slot_data_2,
    input  logic [31:0] slot_data_3,
    output logic        redir_valid,
    output logic [31:0] redir_target,
    output logic [31:0] redir_link,
    output logic [4:0]  redir_rd,
    output logic [2:0]  count,
    output logic [15:0] stall_cycles
);

    localparam logic [2:0]  c_ALLOC_MAX_COUNT = 3'(DEPTH - 2);
    localparam logic [15:0] c_STALL_MAX       = 16'hFFFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]        valid_q,   valid_d;
    logic [DEPTH-1:0][4:0]   rs1_q,     rs1_d;
    logic [DEPTH-1:0][11:0]  imm_q,     imm_d;
    logic [DEPTH-1:0][31:0]  pc_q,      pc_d;
    logic [DEPTH-1:0][4:0]   rd_q,      rd_d;
    logic [1:0]              head_q,    head_d;
    logic [1:0]              tail_q,    tail_d;
    logic [2:0]              count_q,   count_d;
    logic                    rvalid_q,  rvalid_d;
    logic [31:0]             rtarget_q, rtarget_d;
    logic [31:0]             rlink_q,   rlink_d;
    logic [4:0]              rrd_q,     rrd_d;
    logic [15:0]             stall_q,   stall_d;

    // ------------------------------------------------------------------
    // Head-slot view of the forwarding unit
    // ------------------------------------------------------------------
    logic        w_head_rdy;
    logic [31:0] w_head_data;
    logic        w_head_valid;
    logic        w_retire;
    logic        w_alloc0;
    logic        w_alloc1;
    logic [1:0]  w_tail_p1;
    logic [11:0] w_head_imm;
    logic [31:0] w_target_sum;
    logic [31:0] w_link;

    // Only the head's ready/data matter; other ports are observed but unused.
    always_comb begin
        w_head_rdy  = 1'b0;
        w_head_data = 32'd0;
        case (head_q)
            2'd0: begin w_head_rdy = slot_ready_0; w_head_data = slot_data_0; end
            2'd1: begin w_head_rdy = slot_ready_1; w_head_data = slot_data_1; end
            2'd2: begin w_head_rdy = slot_ready_2; w_head_data = slot_data_2; end
            default: begin w_head_rdy = slot_ready_3; w_head_data = slot_data_3; end
        endcase
    end

    assign alloc_ready  = (count_q <= c_ALLOC_MAX_COUNT);
    assign w_head_valid = valid_q[head_q];
    assign w_retire     = w_head_valid & w_head_rdy & ~flush;
    // Lane 1 is only honoured together with lane 0 (older lane first).
    assign w_alloc0     = alloc_ready & alloc_v0 & ~flush;
    assign w_alloc1     = w_alloc0 & alloc_v1;
    assign w_tail_p1    = tail_q + 2'd1;

    assign w_head_imm   = imm_q[head_q];
    assign w_target_sum = w_head_data + {{20{w_head_imm[11]}}, w_head_imm};
    assign w_link       = pc_q[head_q] + 32'd4;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        valid_d   = valid_q;
        rs1_d     = rs1_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rvalid_d  = 1'b0;
        rtarget_d = rtarget_q;
        rlink_d   = rlink_q;
        rrd_d     = rrd_q;
        stall_d   = stall_q;

        // Stall counting looks only at the head's state; flush does not clear it.
        if (w_head_valid && !w_head_rdy && (stall_q != c_STALL_MAX)) begin
            stall_d = stall_q + 16'd1;
        end

        if (flush) begin
            valid_d = '0;
            head_d  = 2'd0;
            tail_d  = 2'd0;
            count_d = 3'd0;
        end else begin
            // Retire first. Allocation needs two free slots, so the slots it
            // writes can never be the head being retired.
            if (w_retire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + 2'd1;
                rvalid_d        = 1'b1;
                rtarget_d       = {w_target_sum[31:1], 1'b0};
                rlink_d         = w_link;
                rrd_d           = rd_q[head_q];
            end
            if (w_alloc0) begin
                valid_d[tail_q] = 1'b1;
                rs1_d[tail_q]   = alloc_rs1_0;
                imm_d[tail_q]   = alloc_imm_0;
                pc_d[tail_q]    = alloc_pc_0;
                rd_d[tail_q]    = alloc_rd_0;
                tail_d          = w_tail_p1;
            end
            if (w_alloc1) begin
                valid_d[w_tail_p1] = 1'b1;
                rs1_d[w_tail_p1]   = alloc_rs1_1;
                imm_d[w_tail_p1]   = alloc_imm_1;
                pc_d[w_tail_p1]    = alloc_pc_1;
                rd_d[w_tail_p1]    = alloc_rd_1;
                tail_d             = tail_q + 2'd2;
            end
            count_d = count_q + {2'b00, w_alloc0} + {2'b00, w_alloc1}
                    - {2'b00, w_retire};
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            rs1_q     <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            rd_q      <= '0;
            head_q    <= 2'd0;
            tail_q    <= 2'd0;
            count_q   <= 3'd0;
            rvalid_q  <= 1'b0;
            rtarget_q <= 32'd0;
            rlink_q   <= 32'd0;
            rrd_q     <= 5'd0;
            stall_q   <= 16'd0;
        end else begin
            valid_q   <= valid_d;
            rs1_q     <= rs1_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rvalid_q  <= rvalid_d;
            rtarget_q <= rtarget_d;
            rlink_q   <= rlink_d;
            rrd_q     <= rrd_d;
            stall_q   <= stall_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign slot_rs1_0   = valid_q[0] ? rs1_q[0] : 5'd0;
    assign slot_rs1_1   = valid_q[1] ? rs1_q[1] : 5'd0;
    assign slot_rs1_2   = valid_q[2] ? rs1_q[2] : 5'd0;
    assign slot_rs1_3   = valid_q[3] ? rs1_q[3] : 5'd0;
    assign redir_valid  = rvalid_q;
    assign redir_target = rtarget_q;
    assign redir_link   = rlink_q;
    assign redir_rd     = rrd_q;
    assign count        = count_q;
    assign stall_cycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_jalr_wait_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_jalr_wait_queue
// Purpose  : Self-checking bench for jalr_wait_queue. Directed scenarios and
//            a randomized phase are scored against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jalr_wait_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        alloc_v0, alloc_v1;
    logic [4:0]  alloc_rs1_0, alloc_rs1_1;
    logic [11:0] alloc_imm_0, alloc_imm_1;
    logic [31:0] alloc_pc_0, alloc_pc_1;
    logic [4:0]  alloc_rd_0, alloc_rd_1;
    logic        alloc_ready;
    logic [4:0]  slot_rs1_0, slot_rs1_1, slot_rs1_2, slot_rs1_3;
    logic        redir_valid;
    logic [31:0] redir_target, redir_link;
    logic [4:0]  redir_rd;
    logic [2:0]  count;
    logic [15:0] stall_cycles;

    logic        rdy_a [4];
    logic [31:0] dat_a [4];

    always #5 clk = ~clk;

    jalr_wait_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_v0(alloc_v0), .alloc_v1(alloc_v1),
        .alloc_rs1_0(alloc_rs1_0), .alloc_rs1_1(alloc_rs1_1),
        .alloc_imm_0(alloc_imm_0), .alloc_imm_1(alloc_imm_1),
        .alloc_pc_0(alloc_pc_0), .alloc_pc_1(alloc_pc_1),
        .alloc_rd_0(alloc_rd_0), .alloc_rd_1(alloc_rd_1),
        .alloc_ready(alloc_ready),
        .slot_rs1_0(slot_rs1_0), .slot_rs1_1(slot_rs1_1),
        .slot_rs1_2(slot_rs1_2), .slot_rs1_3(slot_rs1_3),
        .slot_ready_0(rdy_a[0]), .slot_ready_1(rdy_a[1]),
        .slot_ready_2(rdy_a[2]), .slot_ready_3(rdy_a[3]),
        .slot_data_0(dat_a[0]), .slot_data_1(dat_a[1]),
        .slot_data_2(dat_a[2]), .slot_data_3(dat_a[3]),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .redir_link(redir_link), .redir_rd(redir_rd),
        .count(count), .stall_cycles(stall_cycles)
    );

    // ------------------------------------------------------------------
    // Reference model: program-ordered queue of pending JALRs; the oldest
    // sits in slot hidx, younger ones in the following slots (mod 4).
    // ------------------------------------------------------------------
    typedef struct {
        logic [4:0]  rs1;
        logic [11:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
    } ent_t;

    ent_t        q[$];
    int          hidx;
    logic        m_rv;
    logic [31:0] m_tgt, m_link;
    logic [4:0]  m_rd;
    int          m_stall;

    int tests = 0;
    int fails = 0;

    task automatic model_reset();
        q.delete();
        hidx = 0; m_rv = 1'b0; m_tgt = 32'd0; m_link = 32'd0; m_rd = 5'd0;
        m_stall = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [4:0] e [4];
        for (int i = 0; i < 4; i++) e[i] = 5'd0;
        for (int k = 0; k < q.size(); k++) e[(hidx + k) % 4] = q[k].rs1;
        chk("count",        {29'd0, count},          q.size());
        chk("alloc_ready",  {31'd0, alloc_ready},    (q.size() <= 2) ? 1 : 0);
        chk("redir_valid",  {31'd0, redir_valid},    {31'd0, m_rv});
        chk("redir_target", redir_target,            m_tgt);
        chk("redir_link",   redir_link,              m_link);
        chk("redir_rd",     {27'd0, redir_rd},       {27'd0, m_rd});
        chk("stall_cycles", {16'd0, stall_cycles},   m_stall);
        chk("slot_rs1_0",   {27'd0, slot_rs1_0},     {27'd0, e[0]});
        chk("slot_rs1_1",   {27'd0, slot_rs1_1},     {27'd0, e[1]});
        chk("slot_rs1_2",   {27'd0, slot_rs1_2},     {27'd0, e[2]});
        chk("slot_rs1_3",   {27'd0, slot_rs1_3},     {27'd0, e[3]});
    endtask

    // Advance one clock: predict from the current inputs, then compare.
    task automatic cycle();
        logic        rdy;
        logic [31:0] d, sum;
        int          sz;
        ent_t        e;
        rdy = rdy_a[hidx];
        d   = dat_a[hidx];
        sz  = q.size();
        if (sz > 0 && !rdy && m_stall < 65535) m_stall++;
        m_rv = 1'b0;
        if (flush) begin
            q.delete();
            hidx = 0;
        end else begin
            if (sz > 0 && rdy) begin
                e      = q.pop_front();
                sum    = d + {{20{e.imm[11]}}, e.imm};
                m_tgt  = sum & 32'hFFFF_FFFE;
                m_link = e.pc + 32'd4;
                m_rd   = e.rd;
                m_rv   = 1'b1;
                hidx   = (hidx + 1) % 4;
            end
            if (sz <= 2 && alloc_v0) begin
                q.push_back('{alloc_rs1_0, alloc_imm_0, alloc_pc_0, alloc_rd_0});
                if (alloc_v1)
                    q.push_back('{alloc_rs1_1, alloc_imm_1, alloc_pc_1, alloc_rd_1});
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic alloc(input logic v0, input logic v1,
                         input logic [4:0] r0, input logic [11:0] i0,
                         input logic [31:0] p0, input logic [4:0] d0,
                         input logic [4:0] r1, input logic [11:0] i1,
                         input logic [31:0] p1, input logic [4:0] d1);
        alloc_v0 = v0; alloc_v1 = v1;
        alloc_rs1_0 = r0; alloc_imm_0 = i0; alloc_pc_0 = p0; alloc_rd_0 = d0;
        alloc_rs1_1 = r1; alloc_imm_1 = i1; alloc_pc_1 = p1; alloc_rd_1 = d1;
    endtask

    task automatic idle();
        alloc(1'b0, 1'b0, 5'd0, 12'd0, 32'd0, 5'd0, 5'd0, 12'd0, 32'd0, 5'd0);
        flush = 1'b0;
    endtask

    // Head port gets (r, d); non-head ports get noise that must be ignored.
    task automatic head(input logic r, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            rdy_a[i] = 1'($urandom_range(0, 1));
            dat_a[i] = $urandom;
        end
        rdy_a[hidx] = r;
        dat_a[hidx] = d;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin rdy_a[i] = 1'b0; dat_a[i] = 32'd0; end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();                                   // reset values under reset
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_all();

        // Basic: pc 0x100, imm 0x010, data 0x2001 -> target 0x2010, link 0x104
        alloc(1, 0, 5'd5, 12'h010, 32'h100, 5'd1, 5'd0, 12'd0, 32'd0, 5'd0);
        head(0, 32'd0);
        cycle();
        chk("t1_slot_rs1", {27'd0, slot_rs1_0}, 32'd5);
        idle(); head(1, 32'h2001);
        cycle();
        chk("t1_valid",  {31'd0, redir_valid}, 32'd1);
        chk("t1_target", redir_target, 32'h2010);
        chk("t1_link",   redir_link,   32'h104);
        chk("t1_count",  {29'd0, count}, 32'd0);
        head(0, 32'd0);
        cycle();                                       // pulse ends, payload held

        // Negative immediate and 32-bit wrap
        alloc(1, 0, 5'd7, 12'hFFF, 32'h200, 5'd2, 5'd0, 12'd0, 32'd0, 5'd0);
        cycle();
        idle(); head(1, 32'h1000);
        cycle();
        chk("t2_neg_imm", redir_target, 32'h0000_0FFE);
        alloc(1, 0, 5'd9, 12'h002, 32'hFFFF_FFFC, 5'd3, 5'd0, 12'd0, 32'd0, 5'd0);
        head(0, 32'd0);
        cycle();
        idle(); head(1, 32'hFFFF_FFFF);
        cycle();
        chk("t2_wrap_tgt",  redir_target, 32'h0);
        chk("t2_wrap_link", redir_link,   32'h0);

        // Dual allocate, head stalled 5 cycles, then back-to-back redirects
        alloc(1, 1, 5'd10, 12'h004, 32'h300, 5'd4, 5'd11, 12'h008, 32'h304, 5'd5);
        head(0, 32'd0);
        cycle();
        idle();
        repeat (5) begin head(0, $urandom); cycle(); end
        chk("t3_stall", {16'd0, stall_cycles}, 32'd5);
        head(1, 32'h4000);
        cycle();
        chk("t3_first_link", redir_link, 32'h304);
        head(1, 32'h5000);
        cycle();
        chk("t3_second_link", redir_link, 32'h308);
        chk("t3_second_rd",   {27'd0, redir_rd}, 32'd5);
        head(0, 32'd0);
        cycle();

        // Move head to slot 3, then fill to 4 across the 3->0 wrap
        repeat (2) begin
            alloc(1, 0, 5'd12, 12'h0, 32'h400, 5'd6, 5'd0, 12'd0, 32'd0, 5'd0);
            head(0, 32'd0);
            cycle();
            idle(); head(1, 32'h10);
            cycle();
        end
        alloc(1, 1, 5'd13, 12'h1, 32'h500, 5'd7, 5'd14, 12'h2, 32'h504, 5'd8);
        head(0, 32'd0);
        cycle();
        alloc(1, 1, 5'd15, 12'h3, 32'h508, 5'd9, 5'd16, 12'h4, 32'h50C, 5'd10);
        head(0, 32'd0);
        cycle();
        chk("t4_full_count", {29'd0, count}, 32'd4);
        chk("t4_full_ready", {31'd0, alloc_ready}, 32'd0);
        alloc(1, 1, 5'd17, 12'h5, 32'h600, 5'd11, 5'd18, 12'h6, 32'h604, 5'd12);
        head(0, 32'd0);
        cycle();                                       // ignored while full
        chk("t4_ignored", {29'd0, count}, 32'd4);
        head(1, 32'h100);
        cycle();                                       // alloc at count 4 still ignored
        chk("t4_link0", redir_link, 32'h504);
        head(1, 32'h100);
        cycle();                                       // attempt at count 3 ignored
        chk("t4_link1", redir_link, 32'h508);
        idle();
        head(1, 32'h100); cycle();
        chk("t4_link2", redir_link, 32'h50C);
        head(1, 32'h100); cycle();
        chk("t4_link3", redir_link, 32'h510);
        chk("t4_empty", {29'd0, count}, 32'd0);

        // Retire plus dual allocate at count 2, then flush with head ready
        alloc(1, 1, 5'd19, 12'h0, 32'h700, 5'd13, 5'd20, 12'h0, 32'h704, 5'd14);
        head(0, 32'd0);
        cycle();
        alloc(1, 1, 5'd21, 12'h0, 32'h708, 5'd15, 5'd22, 12'h0, 32'h70C, 5'd16);
        head(1, 32'h800);
        cycle();
        chk("t5_count3", {29'd0, count}, 32'd3);
        alloc(1, 0, 5'd23, 12'h0, 32'h710, 5'd17, 5'd0, 12'd0, 32'd0, 5'd0);
        flush = 1'b1;
        head(1, 32'h900);
        cycle();
        chk("t5_flush_valid", {31'd0, redir_valid}, 32'd0);
        chk("t5_flush_count", {29'd0, count}, 32'd0);
        idle();

        // Asynchronous reset mid-stream with head ready
        alloc(1, 1, 5'd24, 12'h0, 32'hA00, 5'd18, 5'd25, 12'h0, 32'hA04, 5'd19);
        head(0, 32'd0);
        cycle();
        idle(); head(1, 32'h1234);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_async_count", {29'd0, count}, 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        head(1, 32'h1234);
        cycle();
        chk("t6_no_stale", {31'd0, redir_valid}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            alloc(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
                  5'($urandom), 12'($urandom), $urandom, 5'($urandom),
                  5'($urandom), 12'($urandom), $urandom, 5'($urandom));
            flush = 1'($urandom_range(0, 99) < 3);
            for (int i = 0; i < 4; i++) begin
                rdy_a[i] = 1'($urandom_range(0, 1));
                dat_a[i] = $urandom;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
